// File: rtl/linebuf_pkg.sv
// linebuf_pkg: shared sizing defaults and width helper for the 3-row line buffer.
package linebuf_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int IMG_WIDTH_DEF  = 64;
  localparam int IMG_HEIGHT_DEF = 64;
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  localparam int COL_W = clog2w(IMG_WIDTH_DEF);
  localparam int ROW_W = clog2w(IMG_HEIGHT_DEF);
endpackage

// File: rtl/line_mem.sv
// line_mem: single-port line memory, combinational read of the old word, write at the clock edge.
module line_mem
  import linebuf_pkg::*;
#(
  parameter int  DW    = DATA_WIDTH_DEF,
  parameter int  DEPTH = IMG_WIDTH_DEF,
  localparam int AW    = clog2w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];
  assign rdata = mem_q[addr];
  // Contents are deliberately not reset; stale rows are masked by the controller.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end
endmodule

// File: rtl/linebuf_3row.sv
// linebuf_3row: raster line buffer feeding a 3x3 window register with column taps, strobes and window-valid tracking.
// Define LINEBUF_ZERO_PAD_EN to zero the top-row taps and flag windows from row 0 onward.
module linebuf_3row
  import linebuf_pkg::*;
#(
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int  IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int  IMG_HEIGHT = IMG_HEIGHT_DEF,
  localparam int CW         = clog2w(IMG_WIDTH),
  localparam int RW         = clog2w(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  Rst_linebuf,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_row_n,
  output logic [DATA_WIDTH-1:0] out_row_n_1,
  output logic [DATA_WIDTH-1:0] out_row_n_2,
  output logic                  Wr_window,
  output logic                  Shift_window,
  output logic                  window_valid,
  output logic [RW-1:0]         win_row,
  output logic [CW-1:0]         win_col,
  output logic                  frame_done
);
  logic accept, last_col, last_row, win_ok, pad_n1, pad_n2;
  logic [DATA_WIDTH-1:0] mem1_rd, mem0_rd;
  logic [CW-1:0] col_q, col_d, cc_q, cc_d, win_col_q, win_col_d;
  logic [RW-1:0] row_q, row_d, cr_q, cr_d, win_row_q, win_row_d;
  logic [DATA_WIDTH-1:0] tap_n_q, tap_n_d, tap_n1_q, tap_n1_d, tap_n2_q, tap_n2_d;
  logic stb_q, stb_d, done_q, done_d, v1_q, v1_d, win_valid_q, win_valid_d;
  assign in_ready = out_ready;
  assign accept   = in_valid & out_ready;
  assign last_col = col_q == CW'(IMG_WIDTH - 1);
  assign last_row = row_q == RW'(IMG_HEIGHT - 1);
`ifdef LINEBUF_ZERO_PAD_EN
  assign pad_n1 = row_q == '0;
  assign pad_n2 = row_q < RW'(2);
  assign win_ok = col_q >= CW'(2);
`else
  assign pad_n1 = 1'b0;
  assign pad_n2 = 1'b0;
  assign win_ok = (col_q >= CW'(2)) && (row_q >= RW'(2));
`endif
  line_mem #(.DW(DATA_WIDTH), .DEPTH(IMG_WIDTH)) mem1 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(in_pixel), .rdata(mem1_rd)
  );
  line_mem #(.DW(DATA_WIDTH), .DEPTH(IMG_WIDTH)) mem0 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(mem1_rd), .rdata(mem0_rd)
  );
  // Stage 1 captures the accept (taps, strobes, centre); stage 2 reports the completed window.
  always_comb begin
    col_d       = accept ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d       = (accept && last_col) ? (last_row ? '0 : row_q + 1'b1) : row_q;
    tap_n_d     = accept ? in_pixel : tap_n_q;
    tap_n1_d    = accept ? (pad_n1 ? '0 : mem1_rd) : tap_n1_q;
    tap_n2_d    = accept ? (pad_n2 ? '0 : mem0_rd) : tap_n2_q;
    stb_d       = accept;
    done_d      = accept && last_col && last_row;
    v1_d        = accept && win_ok;
    cr_d        = accept ? row_q - 1'b1 : cr_q;
    cc_d        = accept ? col_q - 1'b1 : cc_q;
    win_valid_d = v1_q;
    win_row_d   = v1_q ? cr_q : win_row_q;
    win_col_d   = v1_q ? cc_q : win_col_q;
  end
  always_ff @(posedge clk or negedge Rst_linebuf) begin
    if (!Rst_linebuf) begin
      col_q       <= '0;
      row_q       <= '0;
      tap_n_q     <= '0;
      tap_n1_q    <= '0;
      tap_n2_q    <= '0;
      stb_q       <= 1'b0;
      done_q      <= 1'b0;
      v1_q        <= 1'b0;
      cr_q        <= '0;
      cc_q        <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      tap_n_q     <= tap_n_d;
      tap_n1_q    <= tap_n1_d;
      tap_n2_q    <= tap_n2_d;
      stb_q       <= stb_d;
      done_q      <= done_d;
      v1_q        <= v1_d;
      cr_q        <= cr_d;
      cc_q        <= cc_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end
  assign out_row_n    = tap_n_q;
  assign out_row_n_1  = tap_n1_q;
  assign out_row_n_2  = tap_n2_q;
  assign Wr_window    = stb_q;
  assign Shift_window = stb_q;
  assign frame_done   = done_q;
  assign window_valid = win_valid_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;
endmodule

// File: tb/tb_linebuf_3row.sv
// tb_linebuf_3row: table vectors, corner sequences and random traffic against a frame-image reference model.
module tb_linebuf_3row;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef LINEBUF_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int EXP_WIN = PAD ? H * (W - 2) : (H - 2) * (W - 2);

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_ready;
  logic Wr_window, Shift_window, window_valid, frame_done;
  logic [DW-1:0] in_pixel, out_row_n, out_row_n_1, out_row_n_2;
  logic [1:0] win_row, win_col;

  always #5 clk = ~clk;

  linebuf_3row #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .Rst_linebuf(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .out_ready(out_ready), .out_row_n(out_row_n),
    .out_row_n_1(out_row_n_1), .out_row_n_2(out_row_n_2), .Wr_window(Wr_window),
    .Shift_window(Shift_window), .window_valid(window_valid), .win_row(win_row),
    .win_col(win_col), .frame_done(frame_done)
  );

  typedef struct {
    bit acc;
    int r;
    int c;
    logic [DW-1:0] px;
  } ev_t;

  typedef struct {
    bit v;
    bit ordy;
    logic [DW-1:0] px;
    bit chk_en;
    logic [DW-1:0] n;
    logic [DW-1:0] n1;
    logic [DW-1:0] n2;
    bit stb;
    bit fd;
  } vec_t;

  int checks = 0, failures = 0;
  int mr, mc, win_cnt, fd_cnt;
  logic [DW-1:0] img [H][W];
  ev_t e1, e2;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mr = 0;
    mc = 0;
    e1 = '{0, 0, 0, '0};
    e2 = '{0, 0, 0, '0};
  endtask

  task automatic check_outputs();
    bit wexp;
    chk("wr_window", 32'(Wr_window), 32'(e1.acc));
    chk("shift_window", 32'(Shift_window), 32'(e1.acc));
    chk("frame_done", 32'(frame_done), 32'(e1.acc && e1.r == H - 1 && e1.c == W - 1));
    if (e1.acc) begin
      chk("out_row_n", 32'(out_row_n), 32'(e1.px));
`ifdef LINEBUF_ZERO_PAD_EN
      chk("out_row_n_1", 32'(out_row_n_1), (e1.r >= 1) ? 32'(img[e1.r-1][e1.c]) : 32'd0);
      chk("out_row_n_2", 32'(out_row_n_2), (e1.r >= 2) ? 32'(img[e1.r-2][e1.c]) : 32'd0);
`else
      if (e1.r >= 1) chk("out_row_n_1", 32'(out_row_n_1), 32'(img[e1.r-1][e1.c]));
      if (e1.r >= 2) chk("out_row_n_2", 32'(out_row_n_2), 32'(img[e1.r-2][e1.c]));
`endif
    end
    wexp = e2.acc && e2.c >= 2 && (PAD || e2.r >= 2);
    chk("window_valid", 32'(window_valid), 32'(wexp));
    if (wexp) begin
      chk("win_row", 32'(win_row), 32'((e2.r - 1 + H) % H));
      chk("win_col", 32'(win_col), 32'(e2.c - 1));
    end
    if (window_valid) win_cnt++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic cycle(input bit v, input bit ordy, input logic [DW-1:0] px);
    int pos;
    in_valid  = v;
    out_ready = ordy;
    in_pixel  = px;
    #1 chk("in_ready", 32'(in_ready), 32'(ordy));
    @(posedge clk);
    e2 = e1;
    e1 = '{v && ordy, mr, mc, px};
    if (e1.acc) begin
      img[mr][mc] = px;
      pos = (mr * W + mc + 1) % (W * H);
      mr = pos / W;
      mc = pos % W;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_taps", 32'(out_row_n | out_row_n_1 | out_row_n_2), 32'd0);
    chk("rst_strobes", 32'({Wr_window, Shift_window, frame_done}), 32'd0);
    chk("rst_window", 32'({window_valid, win_row, win_col}), 32'd0);
    out_ready = 1'b0;
    #1 chk("rst_in_ready_lo", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1 chk("rst_in_ready_hi", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int first_src;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_pixel  = '0;
    rst_n     = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Frame 0..15 with a five-cycle downstream stall after pixel 10.
    for (int p = 0; p < 10; p++) vq.push_back('{1, 1, 16'(p), 0, 0, 0, 0, 1, 0});
    vq.push_back('{1, 1, 16'd10, 1, 16'd10, 16'd6, 16'd2, 1, 0});
    repeat (5) vq.push_back('{1, 0, 16'd11, 0, 0, 0, 0, 0, 0});
    vq.push_back('{1, 1, 16'd11, 1, 16'd11, 16'd7, 16'd3, 1, 0});
    vq.push_back('{0, 1, 16'd99, 0, 0, 0, 0, 0, 0});
    vq.push_back('{1, 1, 16'd12, 1, 16'd12, 16'd8, 16'd4, 1, 0});
    vq.push_back('{1, 1, 16'd13, 1, 16'd13, 16'd9, 16'd5, 1, 0});
    vq.push_back('{1, 1, 16'd14, 1, 16'd14, 16'd10, 16'd6, 1, 0});
    vq.push_back('{1, 1, 16'd15, 1, 16'd15, 16'd11, 16'd7, 1, 1});
    vq.push_back('{0, 1, 16'd0, 0, 0, 0, 0, 0, 0});
    vq.push_back('{0, 0, 16'd0, 0, 0, 0, 0, 0, 0});
    win_cnt = 0;
    fd_cnt  = 0;
    foreach (vq[i]) begin
      cycle(vq[i].v, vq[i].ordy, vq[i].px);
      chk("tbl_wr", 32'(Wr_window), 32'(vq[i].stb));
      chk("tbl_done", 32'(frame_done), 32'(vq[i].fd));
      if (vq[i].chk_en) begin
        chk("tbl_row_n", 32'(out_row_n), 32'(vq[i].n));
        chk("tbl_row_n_1", 32'(out_row_n_1), 32'(vq[i].n1));
        chk("tbl_row_n_2", 32'(out_row_n_2), 32'(vq[i].n2));
      end
    end
    chk("frame1_windows", 32'(win_cnt), 32'(EXP_WIN));
    chk("frame1_done", 32'(fd_cnt), 32'd1);

    // Reset after pixel 7, then a full frame from (0,0).
    for (int p = 0; p < 8; p++) cycle(1'b1, 1'b1, 16'(p + 100));
    do_reset();
    win_cnt   = 0;
    fd_cnt    = 0;
    first_src = -1;
    for (int p = 0; p < 16; p++) begin
      cycle(1'b1, 1'b1, 16'(p));
      if (window_valid && first_src < 0) first_src = p - 1;
    end
    repeat (2) cycle(1'b0, 1'b1, 16'd0);
    chk("rst_first_window_pixel", 32'(first_src), PAD ? 32'd2 : 32'd10);
    chk("rst_frame_windows", 32'(win_cnt), 32'(EXP_WIN));
    chk("rst_frame_done", 32'(fd_cnt), 32'd1);

    // Two back-to-back frames with no gap at the wrap.
    win_cnt = 0;
    fd_cnt  = 0;
    for (int p = 0; p < 32; p++) begin
      cycle(1'b1, 1'b1, 16'(p));
      if (p == 26) begin
        chk("f2_row_n", 32'(out_row_n), 32'd26);
        chk("f2_row_n_1", 32'(out_row_n_1), 32'd22);
        chk("f2_row_n_2", 32'(out_row_n_2), 32'd18);
      end
    end
    repeat (2) cycle(1'b0, 1'b1, 16'd0);
    chk("b2b_frame_done", 32'(fd_cnt), 32'd2);
    chk("b2b_windows", 32'(win_cnt), 32'(2 * EXP_WIN));

    // Random traffic with a mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 16'($urandom));
    end
    repeat (2) cycle(1'b0, 1'b1, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
